// File: rtl/coin_pkg.sv
// Shared types and constants for the coin acceptor front end.
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NONE,
    COIN_025,
    COIN_05,
    COIN_1
  } coin_e;

  localparam int CENTS_025 = 25;
  localparam int CENTS_05  = 50;
  localparam int CENTS_1   = 100;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_STUCK_CYCLES    = 64;
  localparam int DEF_COUNT_W         = 8;

  // Fixed-priority pick among pending coins; bit order is {1.00, 0.50, 0.25}.
  function automatic coin_e pick_coin(input logic [2:0] pend);
    if (pend[2])      return COIN_1;
    else if (pend[1]) return COIN_05;
    else if (pend[0]) return COIN_025;
    else              return COIN_NONE;
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin-slot channel: synchroniser, debounce filter, arming and stuck-sensor watch.
// rise_evt and stuck_evt are single-cycle pulses derived from registered state.
module coin_debounce
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int STUCK_CYCLES    = DEF_STUCK_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic coin_sense,
  output logic rise_evt,
  output logic stuck_evt
);

  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = $clog2(STUCK_CYCLES + 1);

  logic          sync1;
  logic          sync_s;
  logic          filt;
  logic          filt_q;
  logic [DW-1:0] db_cnt;
  logic [SW-1:0] stuck_cnt;
  logic          stuck;
  logic [1:0]    prime_cnt;
  logic          primed;
  logic          armed;

  // Two-flop synchroniser for the asynchronous sensor line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync_s <= 1'b0;
    end else begin
      sync1  <= coin_sense;
      sync_s <= sync1;
    end
  end

  // Filtered level only follows the synchronised level after it has disagreed long enough.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      db_cnt <= '0;
      filt   <= 1'b0;
    end else if (sync_s != filt) begin
      if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        filt   <= sync_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Delayed copy of the filtered level for rising-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) filt_q <= 1'b0;
    else       filt_q <= filt;
  end

  // The synchroniser holds reset values for two edges, so arming waits until it carries real samples.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prime_cnt <= 2'd0;
      armed     <= 1'b0;
    end else begin
      if (!primed) prime_cnt <= prime_cnt + 2'd1;
      if (primed && !sync_s && !filt) armed <= 1'b1;
    end
  end

  assign primed = (prime_cnt == 2'd2);

  // Count cycles spent filtered-high; saturate and latch the stuck flag until the line drops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stuck_cnt <= '0;
      stuck     <= 1'b0;
    end else if (filt) begin
      if (stuck_cnt < SW'(STUCK_CYCLES)) stuck_cnt <= stuck_cnt + SW'(1);
      if (stuck_cnt == SW'(STUCK_CYCLES - 1)) stuck <= 1'b1;
    end else begin
      stuck_cnt <= '0;
      stuck     <= 1'b0;
    end
  end

  assign rise_evt  = filt & ~filt_q & armed & ~stuck;
  assign stuck_evt = filt & ~stuck & (stuck_cnt == SW'(STUCK_CYCLES - 1));

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor top: three filtered channels feeding pending bits, a fixed-priority
// arbiter that releases one coin per cycle, the accepted-coin counter and the reject pulse.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int STUCK_CYCLES    = DEF_STUCK_CYCLES,
  parameter int COUNT_W         = DEF_COUNT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               coin_sense_025,
  input  logic               coin_sense_05,
  input  logic               coin_sense_1,
  output logic               money_in025,
  output logic               money_in05,
  output logic               money_in1,
  output logic               coin_reject,
  output logic [COUNT_W-1:0] coin_count
);

  logic [2:0] rise;
  logic [2:0] stuck;
  logic [2:0] pending;
  logic [2:0] pending_nxt;
  logic [2:0] grant;
  logic [2:0] overflow;
  coin_e      grant_coin;

  coin_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .STUCK_CYCLES   (STUCK_CYCLES)
  ) u_ch025 (
    .clock     (clock),
    .reset     (reset),
    .coin_sense(coin_sense_025),
    .rise_evt  (rise[0]),
    .stuck_evt (stuck[0])
  );

  coin_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .STUCK_CYCLES   (STUCK_CYCLES)
  ) u_ch05 (
    .clock     (clock),
    .reset     (reset),
    .coin_sense(coin_sense_05),
    .rise_evt  (rise[1]),
    .stuck_evt (stuck[1])
  );

  coin_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .STUCK_CYCLES   (STUCK_CYCLES)
  ) u_ch1 (
    .clock     (clock),
    .reset     (reset),
    .coin_sense(coin_sense_1),
    .rise_evt  (rise[2]),
    .stuck_evt (stuck[2])
  );

  // Grant the highest-value pending coin; a new event only overflows if its slot stays occupied.
  always_comb begin
    grant      = 3'b000;
    grant_coin = pick_coin(pending);
    case (grant_coin)
      COIN_1:   grant[2] = 1'b1;
      COIN_05:  grant[1] = 1'b1;
      COIN_025: grant[0] = 1'b1;
      default:  grant    = 3'b000;
    endcase
    overflow    = rise & pending & ~grant;
    pending_nxt = (pending & ~grant) | rise;
  end

  // Pending coins waiting for their turn at the output.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pending <= 3'b000;
    else       pending <= pending_nxt;
  end

  // Registered outputs: one money pulse per cycle, counter bump, merged reject pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      money_in025 <= 1'b0;
      money_in05  <= 1'b0;
      money_in1   <= 1'b0;
      coin_reject <= 1'b0;
      coin_count  <= '0;
    end else begin
      money_in025 <= grant[0];
      money_in05  <= grant[1];
      money_in1   <= grant[2];
      coin_reject <= (|overflow) | (|stuck);
      if (|grant) coin_count <= coin_count + COUNT_W'(1);
    end
  end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Upstream front end for coffee_machine: turns raw, bouncy, asynchronous coin-slot sensor lines into clean single-cycle money_in025/money_in05/money_in1 pulses.
- Synchronises, debounces and edge-detects each channel.
- Serialises simultaneous coins so at most one money_in pulse fires per cycle.
- Flags stuck sensors and counts accepted coins.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles required before the filtered level changes (>=2)
STUCK_CYCLES, 64, filtered-high cycles after which a channel is declared stuck
COUNT_W, 8, width of coin_count

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
coin_sense_025  input  1  raw 0.25 slot sensor, asynchronous, may bounce
coin_sense_05  input  1  raw 0.50 slot sensor
coin_sense_1  input  1  raw 1.00 slot sensor
money_in025  output  1  one-cycle pulse, one accepted 0.25 coin
money_in05  output  1  one-cycle pulse, one accepted 0.50 coin
money_in1  output  1  one-cycle pulse, one accepted 1.00 coin
coin_reject  output  1  one-cycle pulse: stuck sensor detected or pending overflow
coin_count  output  COUNT_W  total accepted coins, wraps modulo 2^COUNT_W

Behaviour:
- Reset (async, active-high) clears:
  - all sync flops, filtered levels, debounce/stuck counters, pending bits, arm and stuck flags
  - all outputs, including coin_count = 0
- Per channel, synchronisation and debounce:
  - 2-flop synchroniser produces s.
  - Debounce counter increments while s != filt and clears when s == filt.
  - filt takes s on the edge where the counter reaches DEBOUNCE_CYCLES-1 with s still != filt.
  - Result: filt changes DEBOUNCE_CYCLES cycles after s first differs; any shorter glitch is discarded.
- Arming:
  - A channel is disarmed after reset and arms only once filt has been observed 0.
  - A sensor held high across reset release produces no coin.
- Event:
  - Rising edge of filt on an armed, non-stuck channel sets that channel's pending bit.
  - Uncontended latency: money_inX high exactly DEBOUNCE_CYCLES+3 rising edges after the first edge sampling raw high (7 at default).
- Output arbitration:
  - Each cycle, at most one registered money_in output is asserted, taken from the highest-priority pending bit (1 > 05 > 025).
  - That pending bit clears on the same edge; coin_count increments by 1 in that same cycle.
  - Lower-priority pending coins wait. With three simultaneous coins: money_in1 at L, money_in05 at L+1, money_in025 at L+2.
- Overflow:
  - A new event on a channel whose pending bit is still set and not granted this cycle is dropped.
  - coin_reject pulses; coin_count is unchanged.
  - Same-cycle grant plus new event on the same channel: pending stays set, no reject.
- Stuck detection:
  - Stuck counter counts cycles with filt = 1 and saturates at STUCK_CYCLES.
  - On reaching STUCK_CYCLES the stuck flag sets and coin_reject pulses once.
  - The coin already emitted for that rising edge stands.
  - The stuck flag clears when filt returns to 0, after which the channel operates normally.
- coin_reject:
  - A single pulse even if stuck and overflow coincide, or occur on several channels at once.
- Reset mid-operation:
  - Pending and in-debounce coins are lost; no pulse is emitted after reset release for them.
- Outputs are glitch-free registered signals; money_in025, money_in05 and money_in1 are mutually exclusive (one-hot or zero).

Decomposition:
- Package coin_pkg:
  - typedef enum coin_e {COIN_NONE, COIN_025, COIN_05, COIN_1}
  - cent values CENTS_025 = 25, CENTS_05 = 50, CENTS_1 = 100
  - default parameter constants
- Sub-module coin_debounce (parameters DEBOUNCE_CYCLES, STUCK_CYCLES):
  - contains synchroniser, debounce counter, filt, arm, stuck logic
  - outputs rise_evt and stuck_evt pulses
  - instantiated three times
- The top level holds pending bits, the priority arbiter, output registers, coin_count and coin_reject.

Test Plan:
(defaults; clock period 10 ns)
1. Clean insert: coin_sense_1 high 10 cycles from edge 0 -> money_in1 high only in cycle 7; coin_count = 1; coin_reject never asserted.
2. Bounce: coin_sense_025 toggles every cycle for 6 cycles, then high 8 cycles, then low -> exactly one money_in025 pulse; coin_count = 1.
3. Glitch rejection: coin_sense_05 high 3 cycles, then low -> no money_in pulse; coin_count = 0.
4. Simultaneous: coin_sense_1, coin_sense_05 and coin_sense_025 rise on the same edge, each held 10 cycles -> money_in1 at cycle 7, money_in05 at 8, money_in025 at 9; never two high together; coin_count = 3.
5. Stuck: coin_sense_05 held high 100 cycles -> one money_in05 at cycle 7; coin_reject single pulse 64 cycles after filt rose; no further pulses. Release, then reinsert for 10 cycles -> normal money_in05; coin_count = 2.
6. Reset: reset asserted at cycle 4 of a coin_sense_1 insert, released at cycle 6, sensor held high to cycle 20 -> no money_in1, coin_count = 0. Sensor then low 6 cycles and high 10 cycles -> one money_in1 pulse.
